// File: rtl/jk_stim_sequencer_pkg.sv
// Shared sequencer state encodings, JK function codes and the JK next-state helper.
// Used by the sequencer top and by the reference model that shadows the flip-flop under test.
// Pure definitions, no timing or flow control of its own.
package jk_stim_sequencer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // {J,K} function codes as seen by the flip-flop under test
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic n;
        case ({j, k})
            JK_HOLD:   n = q;
            JK_RESET:  n = 1'b0;
            JK_SET:    n = 1'b1;
            JK_TOGGLE: n = ~q;
            default:   n = q;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jk_ref_model.sv
// Cycle-accurate JK reference flip-flop, sampling the same J/K as the device under test.
// Latency: q_model updates on the same edge as the DUT; model_valid after the first J!=K edge.
// No backpressure: free-running every clock.
module jk_ref_model
    import jk_stim_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic j,
    input  logic k,
    output logic q_model,
    output logic model_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_model     <= 1'b0;
            model_valid <= 1'b0;
        end else begin
            q_model <= jk_next(q_model, j, k);
            // DUT power-up Q is unknown until a set or reset has actually been applied
            if (clr)
                model_valid <= 1'b0;
            else if (j != k)
                model_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/jk_stim_sequencer.sv
// Table-driven J/K stimulus sequencer with a built-in reference model and miscompare counter.
// Latency: start sampled at edge t, first J/K visible after edge t+1; entry i held dwell_i+2 cycles.
// No backpressure: start ignored while busy, stop aborts from any active state on the next edge.
module jk_stim_sequencer
    import jk_stim_sequencer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_en,
    input  logic [$clog2(DEPTH)-1:0]   load_addr,
    input  logic [DWELL_W+1:0]         load_data,
    input  logic [$clog2(DEPTH):0]     num_steps,
    input  logic                       loop,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       q_in,
    output logic                       j_out,
    output logic                       k_out,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic                       mismatch,
    output logic [7:0]                 err_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int EW    = DWELL_W + 2;
    localparam int J_BIT = DWELL_W + 1;
    localparam int K_BIT = DWELL_W;
    localparam logic [AW:0] MAX_STEPS = DEPTH[AW:0];

    logic [EW-1:0]      entry_mem [DEPTH];
    logic [1:0]         state;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [AW:0]        steps_q;
    logic               loop_q;
    logic [AW:0]        steps_clamped;
    logic               start_go;
    logic               last_step;
    logic [EW-1:0]      cur_entry;
    logic               q_model;
    logic               model_valid;

    always_comb begin
        steps_clamped = (num_steps > MAX_STEPS) ? MAX_STEPS : num_steps;
        start_go      = (state == ST_IDLE) && start && !stop && (steps_clamped != '0);
        last_step     = ({1'b0, step_idx} == (steps_q - (AW+1)'(1)));
        cur_entry     = entry_mem[step_idx];
        busy          = (state == ST_FETCH) || (state == ST_DRIVE);
        done          = (state == ST_DONE) && !stop;
    end

    // Program table is deliberately not reset and only writable while idle
    always_ff @(posedge clk) begin
        if (load_en && (state == ST_IDLE))
            entry_mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            j_out     <= 1'b0;
            k_out     <= 1'b0;
            step_idx  <= '0;
            dwell_cnt <= '0;
            steps_q   <= '0;
            loop_q    <= 1'b0;
        end else if (stop && (state != ST_IDLE)) begin
            state <= ST_IDLE;
            j_out <= 1'b0;
            k_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    j_out <= 1'b0;
                    k_out <= 1'b0;
                    if (start_go) begin
                        state    <= ST_FETCH;
                        step_idx <= '0;
                        steps_q  <= steps_clamped;
                        loop_q   <= loop;
                    end
                end
                ST_FETCH: begin
                    j_out     <= cur_entry[J_BIT];
                    k_out     <= cur_entry[K_BIT];
                    dwell_cnt <= cur_entry[DWELL_W-1:0];
                    state     <= ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end else if (last_step) begin
                        if (loop_q) begin
                            step_idx <= '0;
                            state    <= ST_FETCH;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        step_idx <= step_idx + AW'(1);
                        state    <= ST_FETCH;
                    end
                end
                default: begin
                    // DONE: J/K cleared here so the last entry keeps its full hold time
                    j_out <= 1'b0;
                    k_out <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Compare uses pre-edge q_in/q_model, so results trail the drive by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch  <= 1'b0;
            err_count <= '0;
        end else if (start_go) begin
            mismatch  <= 1'b0;
            err_count <= '0;
        end else if (busy && model_valid && (q_in != q_model)) begin
            mismatch <= 1'b1;
            if (err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

    jk_ref_model u_ref (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (start_go),
        .j           (j_out),
        .k           (k_out),
        .q_model     (q_model),
        .model_valid (model_valid)
    );

endmodule

// File: tb/tb_jk_stim_sequencer.sv
// Directed bench for jk_stim_sequencer driving a behavioural JK flip-flop.
// Expected values are hand-derived edge by edge from the sequencer's timing rules.
module tb_jk_stim_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_en;
    logic [2:0] load_addr;
    logic [5:0] load_data;
    logic [3:0] num_steps;
    logic       loop;
    logic       start;
    logic       stop;
    logic       q_in;
    logic       j_out, k_out, busy, done, mismatch;
    logic [2:0] step_idx;
    logic [7:0] err_count;

    logic ff_q;
    logic force_q;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jk_stim_sequencer #(.DEPTH(8), .DWELL_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .num_steps (num_steps),
        .loop      (loop),
        .start     (start),
        .stop      (stop),
        .q_in      (q_in),
        .j_out     (j_out),
        .k_out     (k_out),
        .busy      (busy),
        .done      (done),
        .step_idx  (step_idx),
        .mismatch  (mismatch),
        .err_count (err_count)
    );

    // Flip-flop under test
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ff_q <= 1'b0;
        else
            case ({j_out, k_out})
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
    end

    assign q_in = force_q ? 1'b0 : ff_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic j, input logic k, input int d);
        logic [3:0] dw;
        dw        = d[3:0];
        load_addr = a[2:0];
        load_data = {j, k, dw};
        load_en   = 1'b1;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Start, then take n samples (first one right after the start edge)
    task automatic run_count(input int n, output int jc, output int kc, output int dc, output int bc);
        jc = 0; kc = 0; dc = 0; bc = 0;
        pulse_start();
        for (int i = 0; i < n; i++) begin
            jc += int'(j_out);
            kc += int'(k_out);
            dc += int'(done);
            bc += int'(busy);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int jc, kc, dc, bc, wraps, maxidx;
        logic [2:0] prev;
        logic [13:0] qv, jv, kv, dv;

        rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        num_steps = '0; loop = 1'b0; start = 1'b0; stop = 1'b0; force_q = 1'b0;
        #12;
        check("rst_j", j_out, 0);
        check("rst_k", k_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", step_idx, 0);
        check("rst_mm", mismatch, 0);
        check("rst_err", err_count, 0);
        rst_n = 1'b1;
        tick();

        // Single step: J held dwell+2 = 5 cycles, one done pulse
        load(0, 1'b1, 1'b0, 3);
        num_steps = 4'd1; loop = 1'b0;
        run_count(12, jc, kc, dc, bc);
        check("single_jcycles", jc, 5);
        check("single_kcycles", kc, 0);
        check("single_done", dc, 1);
        check("single_busy", bc, 5);
        check("single_idle", busy, 0);
        check("single_err", err_count, 0);

        // Toggle sequence
        load(0, 1'b1, 1'b0, 0);
        load(1, 1'b1, 1'b1, 3);
        load(2, 1'b0, 1'b0, 1);
        load(3, 1'b0, 1'b1, 0);
        num_steps = 4'd4;
        pulse_start();
        for (int i = 0; i < 14; i++) begin
            qv[i] = ff_q; jv[i] = j_out; kv[i] = k_out; dv[i] = done;
            tick();
        end
        check("tog_q", qv, 14'b00_0000_1010_1111);
        check("tog_j", jv, 14'b00_0000_1111_1110);
        check("tog_k", kv, 14'b01_1000_1111_1000);
        check("tog_done", dv, 14'b01_0000_0000_0000);
        check("tog_mm", mismatch, 0);
        check("tog_err", err_count, 0);

        // Fault injection: Q stuck at 0
        force_q = 1'b1;
        load(0, 1'b1, 1'b0, 2);
        num_steps = 4'd1;
        pulse_start();
        tick(); tick();
        check("fault_mm_s2", mismatch, 0);
        tick();
        check("fault_mm_s3", mismatch, 1);
        check("fault_err_s3", err_count, 1);
        repeat (5) tick();
        check("fault_err_end", err_count, 2);
        check("fault_mm_end", mismatch, 1);

        // Loop, then stop during the third pass with Q still stuck
        load(0, 1'b1, 1'b0, 1);
        load(1, 1'b1, 1'b0, 1);
        num_steps = 4'd2; loop = 1'b1;
        wraps = 0; dc = 0;
        pulse_start();
        check("loop_clr_err", err_count, 0);
        dc += int'(done);
        for (int i = 1; i <= 14; i++) begin
            prev = step_idx;
            tick();
            if (prev == 3'd1 && step_idx == 3'd0) wraps++;
            dc += int'(done);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_j", j_out, 0);
        check("stop_err", err_count, 13);
        repeat (3) begin
            dc += int'(done);
            tick();
        end
        check("loop_wraps", wraps, 2);
        check("stop_nodone", dc, 0);
        check("stop_err_kept", err_count, 13);
        check("stop_mm_kept", mismatch, 1);
        force_q = 1'b0; loop = 1'b0;

        // start and stop together in IDLE: stop wins
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", busy, 0);

        // Zero steps never starts
        num_steps = 4'd0;
        pulse_start();
        check("zero_busy", busy, 0);
        tick();
        check("zero_busy2", busy, 0);

        // Count 15 clamps to 8 entries of dwell 0: 16 busy cycles
        for (int a = 0; a < 8; a++) load(a, 1'b1, 1'b0, 0);
        num_steps = 4'd15;
        bc = 0; dc = 0; maxidx = 0;
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            bc += int'(busy);
            dc += int'(done);
            if (int'(step_idx) > maxidx) maxidx = int'(step_idx);
            tick();
        end
        check("clamp_busy", bc, 16);
        check("clamp_done", dc, 1);
        check("clamp_maxidx", maxidx, 7);

        // Table write while busy is dropped
        load(0, 1'b1, 1'b0, 3);
        num_steps = 4'd1;
        pulse_start();
        tick();
        load(0, 1'b0, 1'b1, 0);
        repeat (10) tick();
        run_count(12, jc, kc, dc, bc);
        check("lock_jcycles", jc, 5);
        check("lock_kcycles", kc, 0);

        // Long forced-mismatch run saturates the counter
        force_q = 1'b1;
        load(0, 1'b1, 1'b0, 15);
        loop = 1'b1;
        pulse_start();
        repeat (300) tick();
        check("sat_err", err_count, 255);
        check("sat_mm", mismatch, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0; force_q = 1'b0; loop = 1'b0;
        check("sat_stop_busy", busy, 0);

        // Asynchronous reset in DRIVE of entry 1
        load(0, 1'b0, 1'b1, 0);
        load(1, 1'b1, 1'b0, 3);
        num_steps = 4'd2;
        pulse_start();
        tick(); tick(); tick();
        check("pre_rst_idx", step_idx, 1);
        check("pre_rst_j", j_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_j", j_out, 0);
        check("arst_k", k_out, 0);
        check("arst_busy", busy, 0);
        check("arst_idx", step_idx, 0);
        #1 rst_n = 1'b1;
        pulse_start();
        check("restart_busy", busy, 1);
        check("restart_idx", step_idx, 0);
        tick();
        check("restart_j", j_out, 0);
        check("restart_k", k_out, 1);
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
